// File: rtl/gb_bus_pkg.sv
// gb_bus_pkg: bus master states, cartridge chip-select window and MBC5 register decode constants.
package gb_bus_pkg;
  typedef enum logic [2:0] {RSTSEQ, IDLE, SETUP, STROBE, HOLD, DONE} state_t;
  localparam logic [15:0] CS_LO = 16'hA000;
  localparam logic [15:0] CS_HI = 16'hFDFF;
  localparam logic [15:0] RAMEN_LO = 16'h0000;
  localparam logic [15:0] RAMEN_HI = 16'h1FFF;
  localparam logic [15:0] ROMLO_LO = 16'h2000;
  localparam logic [15:0] ROMLO_HI = 16'h2FFF;
  localparam logic [15:0] ROMHI_LO = 16'h3000;
  localparam logic [15:0] ROMHI_HI = 16'h3FFF;
  localparam logic [15:0] RAMB_LO = 16'h4000;
  localparam logic [15:0] RAMB_HI = 16'h5FFF;
  localparam logic [8:0] ROM_BANK_RST = 9'h001;
  localparam logic [3:0] RAM_BANK_RST = 4'h0;
  localparam logic RAM_EN_RST = 1'b0;
  function automatic logic in_range(input logic [15:0] a, input logic [15:0] lo, input logic [15:0] hi);
    return a >= lo && a <= hi;
  endfunction
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/gb_bus_master_mbc5_shadow.sv
// mbc5_shadow: snoops completed bus writes and mirrors the MBC5 bank and RAM-enable registers.
module mbc5_shadow
  import gb_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [7:0]  data,
  output logic [8:0]  rom_bank,
  output logic [3:0]  ram_bank,
  output logic        ram_en
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_bank <= ROM_BANK_RST;
      ram_bank <= RAM_BANK_RST;
      ram_en <= RAM_EN_RST;
    end else if (clr) begin
      rom_bank <= ROM_BANK_RST;
      ram_bank <= RAM_BANK_RST;
      ram_en <= RAM_EN_RST;
    end else if (we) begin
      if (in_range(addr, RAMEN_LO, RAMEN_HI)) ram_en <= data == 8'h0A;
      if (in_range(addr, ROMLO_LO, ROMLO_HI)) rom_bank[7:0] <= data;
      if (in_range(addr, ROMHI_LO, ROMHI_HI)) rom_bank[8] <= data[0];
      if (in_range(addr, RAMB_LO, RAMB_HI)) ram_bank <= data[3:0];
    end
  end
endmodule

// File: rtl/gb_bus_master.sv
// gb_bus_master: turns valid/ready byte commands into timed GB cartridge bus cycles and drives the cart reset pulse.
// Define GB_BUS_MBC_SHADOW_EN to build the MBC5 shadow registers; otherwise the shadow outputs sit at reset values.
module gb_bus_master
  import gb_bus_pkg::*;
#(
  parameter int T_SETUP = 2,
  parameter int T_STROBE = 4,
  parameter int T_HOLD = 2,
  parameter int RST_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  input  logic        cart_rst_req,
  output logic [15:0] gb_a,
  output logic        gb_cs,
  output logic        gb_rd,
  output logic        gb_wr,
  output logic        gb_rst,
  output logic [7:0]  gb_d_out,
  output logic        gb_d_oe,
  input  logic [7:0]  gb_d_in,
  output logic [8:0]  shadow_rom_bank,
  output logic [3:0]  shadow_ram_bank,
  output logic        shadow_ram_en
);
  localparam int CW = $clog2(max2(max2(T_SETUP, T_STROBE), max2(T_HOLD, RST_CYCLES))) + 1;
  if (T_SETUP < 1 || T_STROBE < 1 || T_HOLD < 1 || RST_CYCLES < 1) begin : g_bad_param
    $error("gb_bus_master: timing parameters must all be >= 1");
  end
  state_t state, nxt;
  logic [CW-1:0] cnt, nxt_cnt;
  logic [15:0] addr;
  logic [7:0] wdata;
  logic wr, accept, busy, last;
  // RSTSEQ loads RST_CYCLES (not -1): the extra final cycle has GB_RST released before IDLE
  function automatic logic [CW-1:0] load(input state_t s);
    return s == RSTSEQ ? CW'(RST_CYCLES) : s == SETUP ? CW'(T_SETUP - 1) :
           s == STROBE ? CW'(T_STROBE - 1) : s == HOLD ? CW'(T_HOLD - 1) : '0;
  endfunction
  assign last = cnt == '0;
  assign busy = state == SETUP || state == STROBE || state == HOLD;
  assign cmd_ready = (state == IDLE || state == DONE) && !cart_rst_req;
  assign accept = cmd_valid && cmd_ready;
  always_comb begin
    nxt = state;
    case (state)
      RSTSEQ: nxt = last ? IDLE : RSTSEQ;
      SETUP: nxt = last ? STROBE : SETUP;
      STROBE: nxt = last ? HOLD : STROBE;
      HOLD: nxt = last ? DONE : HOLD;
      default: nxt = cart_rst_req ? RSTSEQ : accept ? SETUP : IDLE;
    endcase
    nxt_cnt = nxt != state ? load(nxt) : last ? cnt : cnt - 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RSTSEQ;
      cnt <= CW'(RST_CYCLES);
      addr <= '0;
      wdata <= '0;
      wr <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state <= nxt;
      cnt <= nxt_cnt;
      if (accept) begin
        addr <= cmd_addr;
        wr <= cmd_wr;
      end
      if (accept && cmd_wr) wdata <= cmd_wdata;
      if (state == STROBE && last && !wr) rsp_rdata <= gb_d_in;
    end
  end
  assign gb_a = addr;
  assign gb_cs = !(busy && in_range(addr, CS_LO, CS_HI));
  assign gb_rd = !(state == STROBE && !wr);
  assign gb_wr = !(state == STROBE && wr);
  assign gb_d_oe = busy && wr;
  assign gb_d_out = wdata;
  assign gb_rst = !(state == RSTSEQ && !last);
  assign rsp_valid = state == DONE;
`ifdef GB_BUS_MBC_SHADOW_EN
  mbc5_shadow u_shadow (
    .clk(clk),
    .rst_n(rst_n),
    .clr(state == RSTSEQ),
    .we(state == DONE && wr),
    .addr(addr),
    .data(wdata),
    .rom_bank(shadow_rom_bank),
    .ram_bank(shadow_ram_bank),
    .ram_en(shadow_ram_en)
  );
`else
  assign shadow_rom_bank = ROM_BANK_RST;
  assign shadow_ram_bank = RAM_BANK_RST;
  assign shadow_ram_en = RAM_EN_RST;
`endif
endmodule

// File: doc/gb_bus_master.md
Name: gb_bus_master

Overview:
- Host-side initiator for the Game Boy cartridge bus; the other end of the cartridge mapper logic.
- Converts single-byte read/write commands on a valid/ready interface into timed GB bus cycles: GB_A, GB_CS, GB_RD, GB_WR, data bus.
- Generates the cartridge reset pulse.
- Used by the cart flasher/dumper and as the bus driver for mapper verification.

Parameters:
- T_SETUP, 2: CLK cycles the address/CS are valid before the strobe.
- T_STROBE, 4: CLK cycles RD or WR is held low.
- T_HOLD, 2: CLK cycles the address/CS/data are held after the strobe rises.
- RST_CYCLES, 16: CLK cycles GB_RST is held low in the reset sequence.

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous active-low reset
- CMD_VALID  in  1  command request
- CMD_READY  out  1  block can accept a command
- CMD_WR  in  1  1=write, 0=read
- CMD_ADDR  in  16  GB address
- CMD_WDATA  in  8  write data
- RSP_VALID  out  1  one-cycle completion pulse (reads and writes)
- RSP_RDATA  out  8  read data, valid with RSP_VALID
- CART_RST_REQ  in  1  request a cartridge reset sequence
- GB_A  out  16  cartridge address
- GB_CS  out  1  active-low chip select
- GB_RD  out  1  active-low read strobe
- GB_WR  out  1  active-low write strobe
- GB_RST  out  1  active-low cartridge reset
- GB_D_OUT  out  8  data driven to the cart
- GB_D_OE  out  1  1 = drive GB_D_OUT onto the bus (top-level tristate)
- GB_D_IN  in  8  data from the cart

Behaviour:
- States: RSTSEQ, IDLE, SETUP, STROBE, HOLD, DONE.
- Reset values (RST low):
  - state=RSTSEQ; GB_RST=0; GB_CS=GB_RD=GB_WR=1.
  - GB_A=16'h0000; GB_D_OE=0; GB_D_OUT=0.
  - CMD_READY=0; RSP_VALID=0; RSP_RDATA=0.
- RSTSEQ:
  - GB_RST=0 for RST_CYCLES cycles.
  - Then GB_RST=1 and go to IDLE.
- IDLE:
  - CMD_READY=1.
  - Bus idle: strobes high, CS high, OE=0, GB_A holds the last address.
- CART_RST_REQ:
  - Sampled only in IDLE and DONE; takes priority over a simultaneous CMD_VALID (no accept).
  - Goes to RSTSEQ.
  - Ignored during SETUP/STROBE/HOLD: no queuing, and the in-flight transaction completes.
- Accept: CMD_VALID & CMD_READY at an edge. The command is latched and the state goes to SETUP.
- SETUP (T_SETUP cycles):
  - GB_A=CMD_ADDR.
  - GB_CS=0 iff the address is in 16'hA000..16'hFDFF, else 1.
  - For writes: GB_D_OUT=data, GB_D_OE=1.
- STROBE (T_STROBE cycles):
  - GB_RD=0 (read) or GB_WR=0 (write).
  - On reads, RSP_RDATA is registered from GB_D_IN at the edge that leaves STROBE.
- HOLD (T_HOLD cycles): strobes high; A, CS, OE and data unchanged.
- DONE (1 cycle):
  - RSP_VALID=1; CS high; OE=0; CMD_READY=1.
  - An accept here goes directly to SETUP, giving back-to-back transactions with no IDLE cycle.
- Latency: RSP_VALID is high in cycle T_SETUP+T_STROBE+T_HOLD+1 after the accept edge (9 cycles by default).
- Reads drive GB_D_OE=0 throughout.
- GB_RD and GB_WR are never low simultaneously.
- GB_D_OE is never 1 while GB_RD=0.
- Phase counter: sized $clog2(max param)+1. It reloads on each state entry and counts down to zero; no wrap is observable.
- All parameters must be ≥1; an elaboration-time check rejects 0.
- RST asserted mid-transaction: bus outputs go immediately to their reset values, no RSP_VALID is issued, and the state restarts at RSTSEQ.
- RSP_RDATA holds its value until the next read completes.

Optional Feature:
- Macro: GB_BUS_MBC_SHADOW_EN.
- When defined, the block adds outputs SHADOW_ROM_BANK[8:0], SHADOW_RAM_BANK[3:0] and SHADOW_RAM_EN.
- These mirror MBC5 state, updated at the DONE cycle of each completed write:
  - 0x0000-0x1FFF: SHADOW_RAM_EN = (data==8'h0A).
  - 0x2000-0x2FFF: ROM_BANK[7:0] = data.
  - 0x3000-0x3FFF: ROM_BANK[8] = data[0].
  - 0x4000-0x5FFF: RAM_BANK = data[3:0].
- Shadow reset values (RST low, and on entering RSTSEQ): ROM_BANK=9'h001, RAM_BANK=0, RAM_EN=0.
- When the macro is undefined, the outputs exist but are tied to those reset values and no shadow logic is built.

Decomposition:
- Package gb_bus_pkg:
  - state enum;
  - CS window constants 16'hA000/16'hFDFF;
  - MBC5 register decode ranges and shadow reset constants.
- One sub-module, mbc5_shadow: write-snoop register file, instantiated only under GB_BUS_MBC_SHADOW_EN.

Test Plan:
- Release RST -> GB_RST low exactly 16 cycles, then high; CMD_READY rises the following cycle.
- Read 0x4123 with the bench driving GB_D_IN=8'h5A during STROBE:
  - GB_CS=1 and GB_RD low for 4 cycles;
  - RSP_VALID 9 cycles after accept with RSP_RDATA=8'h5A.
- Write 0xA010 data 8'hC3:
  - GB_CS=0, GB_WR low 4 cycles, GB_D_OE=1 from SETUP through HOLD, GB_D_OUT=8'hC3;
  - GB_RD stays high throughout.
- Back-to-back: CMD_VALID held for writes 0x2000/8'h23 then 0x3000/8'h01:
  - second accept in the DONE cycle of the first;
  - with the shadow feature enabled, SHADOW_ROM_BANK=9'h123.
- Write 0x0000/8'h0A then 0x0000/8'h00 -> SHADOW_RAM_EN goes 1 then 0.
- Reset and CART_RST_REQ handling:
  - RST asserted during STROBE -> all bus outputs return to reset values the same cycle and there is no RSP_VALID.
  - CART_RST_REQ together with CMD_VALID in IDLE -> command not accepted and RSTSEQ runs.
